// File: rtl/ib_avf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ib_avf_pkg
//  Description : Shared constants and FSM state encoding for the ib_avf blocks.
//  Revision    : 1.0  initial release
// ============================================================================
package ib_avf_pkg;

  localparam int DURATION_WIDTH = 10;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SNAP  = 2'd2
  } avf_state_e;

endpackage
`default_nettype wire

// File: rtl/ib_avf_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : ib_avf_acc_if
//  Description : Residency FIFO consumer port plus snapshot req/valid/ack port.
//  Revision    : 1.0  initial release
// ============================================================================
interface ib_avf_acc_if
  import ib_avf_pkg::*;
#(
  parameter int DUR_WIDTH    = DURATION_WIDTH,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int CNT_WIDTH    = 16
);

  logic                    dur_push;
  logic [DUR_WIDTH-1:0]    ib_duration;
  logic [WEIGHT_WIDTH-1:0] ace_bits;
  logic                    pop;
  logic                    snap_req;
  logic                    snap_valid;
  logic                    snap_ack;
  logic [ACC_WIDTH-1:0]    snap_acc;
  logic [CNT_WIDTH-1:0]    snap_cnt;
  logic                    overrun;

  modport master (
    output dur_push, ib_duration, ace_bits, snap_req, snap_ack,
    input  pop, snap_valid, snap_acc, snap_cnt, overrun
  );

  modport slave (
    input  dur_push, ib_duration, ace_bits, snap_req, snap_ack,
    output pop, snap_valid, snap_acc, snap_cnt, overrun
  );

endinterface
`default_nettype wire

// File: rtl/ib_avf_mac.sv
`default_nettype none
// ============================================================================
//  Module      : ib_avf_mac
//  Description : Two-stage duration x weight multiply-accumulate with clear.
//                Saturating accumulate when IB_AVF_SAT_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module ib_avf_mac
  import ib_avf_pkg::*;
#(
  parameter int DUR_WIDTH    = DURATION_WIDTH,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_pop,
  input  logic [DUR_WIDTH-1:0]    i_duration,
  input  logic [WEIGHT_WIDTH-1:0] i_weight,
  input  logic                    i_clear,
  output logic                    o_in_flight,
  output logic [ACC_WIDTH-1:0]    o_acc,
  output logic [CNT_WIDTH-1:0]    o_cnt
);

  localparam int c_PROD_WIDTH = DUR_WIDTH + WEIGHT_WIDTH;

  logic [c_PROD_WIDTH-1:0] w_dur_ext;
  logic [c_PROD_WIDTH-1:0] w_wgt_ext;
  logic [c_PROD_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]    w_prod_ext;
  logic [ACC_WIDTH-1:0]    w_acc_nxt;
  logic [CNT_WIDTH-1:0]    w_cnt_nxt;

  logic [c_PROD_WIDTH-1:0] r_prod;
  logic                    r_prod_vld;
  logic [ACC_WIDTH-1:0]    r_acc;
  logic [CNT_WIDTH-1:0]    r_cnt;

  always_comb begin
    w_dur_ext                  = '0;
    w_dur_ext[DUR_WIDTH-1:0]   = i_duration;
    w_wgt_ext                  = '0;
    w_wgt_ext[WEIGHT_WIDTH-1:0] = i_weight;
    w_prod                     = w_dur_ext * w_wgt_ext;
    w_prod_ext                 = '0;
    w_prod_ext[c_PROD_WIDTH-1:0] = r_prod;
  end

`ifdef IB_AVF_SAT_EN
  logic [ACC_WIDTH:0] w_acc_sum;

  // A carry out of the wide sum means the true total no longer fits.
  always_comb begin
    w_acc_sum = {1'b0, r_acc} + {1'b0, w_prod_ext};
    w_acc_nxt = w_acc_sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : w_acc_sum[ACC_WIDTH-1:0];
    w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
  end
`else
  always_comb begin
    w_acc_nxt = r_acc + w_prod_ext;
    w_cnt_nxt = r_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      r_prod_vld <= i_pop;
      if (i_pop) begin
        r_prod <= w_prod;
      end
      if (i_clear) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_prod_vld) begin
        r_acc <= w_acc_nxt;
        r_cnt <= w_cnt_nxt;
      end
    end
  end

  assign o_in_flight = r_prod_vld;
  assign o_acc       = r_acc;
  assign o_cnt       = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ib_avf_acc.sv
`default_nettype none
// ============================================================================
//  Module      : ib_avf_acc
//  Description : Residency FIFO consumer: occupancy tracking, pop control and
//                snapshot FSM around the ib_avf_mac accumulator.
//                Optional macro: IB_AVF_SAT_EN (saturating acc/cnt).
//  Revision    : 1.0  initial release
// ============================================================================
module ib_avf_acc
  import ib_avf_pkg::*;
#(
  parameter int DUR_WIDTH    = DURATION_WIDTH,
  parameter int WEIGHT_WIDTH = 8,
  parameter int ACC_WIDTH    = 32,
  parameter int CNT_WIDTH    = 16
) (
  input  logic          clk,
  input  logic          reset,
  ib_avf_acc_if.slave   bus
);

  localparam logic [1:0] c_ST_RUN   = ST_RUN;
  localparam logic [1:0] c_ST_DRAIN = ST_DRAIN;
  localparam logic [1:0] c_ST_SNAP  = ST_SNAP;

  logic [1:0]           r_state;
  logic [1:0]           r_occ;
  logic                 r_overrun;
  logic [1:0]           w_state_nxt;
  logic                 w_pop;
  logic                 w_clear;
  logic                 w_in_flight;
  logic [ACC_WIDTH-1:0] w_acc;
  logic [CNT_WIDTH-1:0] w_cnt;

  assign w_pop   = (r_state == c_ST_RUN) && (r_occ != 2'd0);
  assign w_clear = (r_state == c_ST_SNAP) && bus.snap_ack;

  // occ mirrors the producer's 2-entry FIFO; a push into a full FIFO loses data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ     <= 2'd0;
      r_overrun <= 1'b0;
    end else begin
      case ({bus.dur_push, w_pop})
        2'b10: begin
          if (r_occ == 2'd2) begin
            r_overrun <= 1'b1;
          end else begin
            r_occ <= r_occ + 2'd1;
          end
        end
        2'b01:   r_occ <= r_occ - 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_RUN:   if (bus.snap_req) w_state_nxt = c_ST_DRAIN;
      c_ST_DRAIN: if (!w_in_flight) w_state_nxt = c_ST_SNAP;
      c_ST_SNAP:  if (bus.snap_ack) w_state_nxt = c_ST_RUN;
      default:    w_state_nxt = c_ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  ib_avf_mac #(
    .DUR_WIDTH    (DUR_WIDTH),
    .WEIGHT_WIDTH (WEIGHT_WIDTH),
    .ACC_WIDTH    (ACC_WIDTH),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_mac (
    .clk         (clk),
    .reset       (reset),
    .i_pop       (w_pop),
    .i_duration  (bus.ib_duration),
    .i_weight    (bus.ace_bits),
    .i_clear     (w_clear),
    .o_in_flight (w_in_flight),
    .o_acc       (w_acc),
    .o_cnt       (w_cnt)
  );

  assign bus.pop        = w_pop;
  assign bus.snap_valid = (r_state == c_ST_SNAP);
  assign bus.snap_acc   = w_acc;
  assign bus.snap_cnt   = w_cnt;
  assign bus.overrun    = r_overrun;

endmodule
`default_nettype wire
